bus_arbiter: RTL

Shared-bus arbiter and bus multiplexer for the system interconnect. Arbitrates up to eight masters (CPU, DMA, peripherals) over the single shared data/control bus using round-robin priority. Grants ownership via a per-master req/ack handshake, drives the owner's data and control onto the bus, and enforces a hold-time watchdog. Sits between the masters' `bus_req`/`bus_ack`/`bus_data_out`/`bus_ctrl_out` ports and the shared `bus`/`ctrl` nets that all slaves and masters read.

---
 rtl/bus_pkg.sv | 23 ++
 rtl/rr_pick.sv | 34 +++
 rtl/bus_arbiter.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/bus_pkg.sv
// Shared definitions for the system bus: widths, control encodings and
// arbiter state encodings.
package bus_pkg;

  localparam int unsigned NMASTERS = 8;
  localparam int unsigned dwidth   = 32;
  localparam int unsigned cwidth   = 3;
  localparam int unsigned CNT_W    = 8;

  typedef enum logic [2:0] {
    CTRL_NONE  = 3'd0,
    CTRL_READ  = 3'd1,
    CTRL_WRITE = 3'd2,
    CTRL_ACK   = 3'd3
  } ctrl_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_TURN  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
// Ports:
//   eligible : candidate vector, one bit per requester
//   last     : index of the most recent winner; search starts at last+1
//   winner   : index of the first eligible bit at or after last+1 (wrapping)
//   any      : high when at least one bit of eligible is set
// N must be a power of two so the index addition wraps naturally.
module rr_pick #(
  parameter int unsigned N = 8,
  parameter int unsigned W = $clog2(N)
) (
  input  logic [N-1:0] eligible,
  input  logic [W-1:0] last,
  output logic [W-1:0] winner,
  output logic         any
);

  logic [W-1:0] idx;

  // Walk last+1 .. last+N; the first hit wins, later hits are ignored.
  always_comb begin
    winner = '0;
    any    = 1'b0;
    idx    = '0;
    for (int k = 1; k <= int'(N); k++) begin
      idx = last + W'(k);
      if (!any && eligible[idx]) begin
        winner = idx;
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin shared-bus arbiter with bus multiplexer and hold watchdog.
// Ports:
//   clk, reset    : clock, asynchronous active-low reset
//   req           : per-master bus request (bit 7 is the CPU)
//   m_data/m_ctrl : concatenated master data/control outputs
//   ack           : registered one-hot grant (or zero)
//   bus_data/ctrl : shared bus, driven from the registered owner
//   owner         : index of the current owner
//   owner_valid   : high while a grant is active
//   timeout_err   : one-cycle pulse when a grant is forcibly released
module bus_arbiter #(
  parameter int unsigned NMASTERS = bus_pkg::NMASTERS,
  parameter int unsigned dwidth   = bus_pkg::dwidth,
  parameter int unsigned cwidth   = bus_pkg::cwidth,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NMASTERS-1:0]          req,
  input  logic [NMASTERS*dwidth-1:0]   m_data,
  input  logic [NMASTERS*cwidth-1:0]   m_ctrl,
  output logic [NMASTERS-1:0]          ack,
  output logic [dwidth-1:0]            bus_data,
  output logic [cwidth-1:0]            bus_ctrl,
  output logic [2:0]                   owner,
  output logic                         owner_valid,
  output logic                         timeout_err
);

  import bus_pkg::arb_state_e;
  import bus_pkg::ST_IDLE;
  import bus_pkg::ST_GRANT;
  import bus_pkg::ST_TURN;
  import bus_pkg::CTRL_NONE;
  import bus_pkg::CNT_W;

  localparam int unsigned OW = 3;

  arb_state_e          state_q, state_d;
  logic [OW-1:0]       owner_q, owner_d;
  logic [OW-1:0]       last_q, last_d;
  logic [NMASTERS-1:0] ack_q, ack_d;
  logic [NMASTERS-1:0] mask_q, mask_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                valid_q, valid_d;
  logic                terr_q, terr_d;

  logic [OW-1:0]       pick_winner;
  logic                pick_any;

  // Masked-off masters have timed out and must drop req once before competing.
  rr_pick #(.N(NMASTERS), .W(OW)) u_pick (
    .eligible (req & ~mask_q),
    .last     (last_q),
    .winner   (pick_winner),
    .any      (pick_any)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      owner_q <= '0;
      last_q  <= OW'(NMASTERS - 1);
      ack_q   <= '0;
      mask_q  <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      ack_q   <= ack_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      terr_q  <= terr_d;
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    ack_d   = ack_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    terr_d  = 1'b0;
    // A mask bit survives only while its master keeps requesting.
    mask_d  = mask_q & req;

    unique case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          owner_d = pick_winner;
          ack_d   = NMASTERS'(1) << pick_winner;
          valid_d = 1'b1;
          cnt_d   = '0;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (!req[owner_q]) begin
          ack_d   = '0;
          valid_d = 1'b0;
          last_d  = owner_q;
          state_d = ST_TURN;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          // This edge is the TIMEOUT-th cycle of the grant: force release.
          ack_d           = '0;
          valid_d         = 1'b0;
          terr_d          = 1'b1;
          mask_d[owner_q] = 1'b1;
          last_d          = owner_q;
          state_d         = ST_TURN;
        end else if (cnt_q != CNT_W'(TIMEOUT)) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_TURN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Bus mux from the registered owner; idle bus reads as zero / CTRL_NONE.
  always_comb begin
    bus_data = '0;
    bus_ctrl = cwidth'(CTRL_NONE);
    if (valid_q) begin
      for (int i = 0; i < int'(NMASTERS); i++) begin
        if (owner_q == OW'(i)) begin
          bus_data = m_data[i*dwidth +: dwidth];
          bus_ctrl = m_ctrl[i*cwidth +: cwidth];
        end
      end
    end
  end

  assign ack         = ack_q;
  assign owner       = owner_q;
  assign owner_valid = valid_q;
  assign timeout_err = terr_q;

endmodule
